// File: rtl/pwm_duty_meter.sv
// PWM duty meter: samples an asynchronous PWM line, measures period and high time, and reports a 4-bit duty level.
// Optional input glitch filter is enabled with `define PWM_METER_FILTER_EN.
module pwm_duty_meter #(
    parameter int CW         = 16,
    parameter int TIMEOUT    = 50000,
    parameter int FILTER_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [3:0]    duty,
    output logic [CW-1:0] period,
    output logic          valid,
    output logic          stuck
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer and optional stability filter
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic s;
    logic s_dly_q;
    logic rise;

    // NOTE: reset every flop here, including the synchronizer, so no X reaches the edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_METER_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    logic          filt_q;
    logic [FW-1:0] flt_cnt_q;

    // The accepted level only follows the synchronizer after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q    <= 1'b0;
            flt_cnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FLT_LAST) begin
            filt_q    <= sync2_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_dly_q <= 1'b0;
        end else begin
            s_dly_q <= s;
        end
    end

    assign rise = s & ~s_dly_q;

    // ------------------------------------------------------------------
    // Measurement, divider and result registers
    // ------------------------------------------------------------------
    state_t          state_q,   state_d;
    logic [CW-1:0]   per_cnt_q, per_cnt_d;
    logic [CW-1:0]   hi_cnt_q,  hi_cnt_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CW-1:0]   p_q,       p_d;
    logic [CW-1:0]   r_q,       r_d;
    logic [3:0]      q_q,       q_d;
    logic [1:0]      div_cnt_q, div_cnt_d;
    logic            pend_q,    pend_d;
    logic [3:0]      duty_q,    duty_d;
    logic [CW-1:0]   period_q,  period_d;
    logic            valid_q,   valid_d;
    logic            stuck_q,   stuck_d;

    logic [CW-1:0]   per_inc;
    logic [CW-1:0]   hi_inc;
    logic [CW:0]     r_dbl;
    logic [CW:0]     r_sub;
    logic            timeout_hit;

    assign per_inc     = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
    assign hi_inc      = (hi_cnt_q  == CNT_MAX) ? hi_cnt_q  : hi_cnt_q  + 1'b1;
    assign r_dbl       = {r_q, 1'b0};
    assign r_sub       = r_dbl - {1'b0, p_q};
    assign timeout_hit = ~rise && (idle_cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            idle_cnt_q <= '0;
            p_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            div_cnt_q  <= '0;
            pend_q     <= 1'b0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only, so every flop
            // samples the values computed in the previous cycle regardless of statement order.
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            p_q        <= p_d;
            r_q        <= r_d;
            q_q        <= q_d;
            div_cnt_q  <= div_cnt_d;
            pend_q     <= pend_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a missing branch would otherwise infer a latch.
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        idle_cnt_d = idle_cnt_q;
        p_d        = p_q;
        r_d        = r_q;
        q_d        = q_q;
        div_cnt_d  = div_cnt_q;
        pend_d     = pend_q;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;

        if (rise) begin
            idle_cnt_d = '0;
            stuck_d    = 1'b0;
        end else if (idle_cnt_q < TMO_LIMIT) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        // Result of the divide that finished last cycle.
        if (pend_q) begin
            duty_d   = q_q;
            period_d = p_q;
            valid_d  = 1'b1;
            pend_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    per_cnt_d = CNT_ONE;
                    hi_cnt_d  = CNT_ONE;
                end
            end

            MEASURE: begin
                per_cnt_d = per_inc;
                if (s) begin
                    hi_cnt_d = hi_inc;
                end
                if (rise) begin
                    p_d       = per_cnt_q;
                    r_d       = hi_cnt_q;
                    q_d       = '0;
                    div_cnt_d = '0;
                    per_cnt_d = CNT_ONE;
                    hi_cnt_d  = CNT_ONE;
                    state_d   = DIVIDE;
                end
            end

            DIVIDE: begin
                // A rise here restarts the period being measured; the divide in flight is unaffected.
                per_cnt_d = per_inc;
                if (s) begin
                    hi_cnt_d = hi_inc;
                end
                if (rise) begin
                    per_cnt_d = CNT_ONE;
                    hi_cnt_d  = CNT_ONE;
                end

                if (r_dbl >= {1'b0, p_q}) begin
                    r_d = r_sub[CW-1:0];
                    q_d = {q_q[2:0], 1'b1};
                end else begin
                    r_d = r_dbl[CW-1:0];
                    q_d = {q_q[2:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 1'b1;

                if (div_cnt_q == 2'd3) begin
                    state_d = MEASURE;
                    pend_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Stuck line overrides everything, including a result still in flight.
        if (timeout_hit) begin
            stuck_d  = 1'b1;
            duty_d   = s ? 4'd15 : 4'd0;
            period_d = '0;
            valid_d  = 1'b1;
            pend_d   = 1'b0;
            state_d  = IDLE;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed self-checking bench for pwm_duty_meter (TIMEOUT shortened to 2000 to keep runs short).
// Glitch-filter scenario runs only when PWM_METER_FILTER_EN is defined.
module tb_pwm_duty_meter;

    localparam int CW      = 16;
    localparam int TIMEOUT = 2000;

    logic          clk;
    logic          rst;
    logic          pwm_in;
    logic [3:0]    duty;
    logic [CW-1:0] period;
    logic          valid;
    logic          stuck;

    int n_checks;
    int n_errors;
    int cyc;
    int vcnt;
    int last_duty;
    int last_period;
    int last_valid_cyc;

    pwm_duty_meter #(
        .CW        (CW),
        .TIMEOUT   (TIMEOUT),
        .FILTER_LEN(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .duty  (duty),
        .period(period),
        .valid (valid),
        .stuck (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every valid pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst && valid) begin
            vcnt           <= vcnt + 1;
            last_duty      <= int'(duty);
            last_period    <= int'(period);
            last_valid_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pwm_periods(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (hi) @(negedge clk);
            pwm_in = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int v0;
    int t_meas;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        vcnt           = 0;
        last_duty      = 0;
        last_period    = 0;
        last_valid_cyc = 0;
        pwm_in         = 1'b0;
        rst            = 1'b1;
        #1;
        check("reset_duty",   32'(duty),   32'd0);
        check("reset_period", 32'(period), 32'd0);
        check("reset_valid",  32'(valid),  32'd0);
        check("reset_stuck",  32'(stuck),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Period 100, high 25: one valid per period after the first rise.
        v0 = vcnt;
        pwm_periods(100, 25, 6);
        check("p100h25_count",  32'(vcnt - v0),  32'd5);
        check("p100h25_period", 32'(last_period), 32'd100);
        check("p100h25_duty",   32'(last_duty),   32'd4);

        // Reset asserted while a divide is in progress.
        pwm_in = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        v0  = vcnt;
        rst = 1'b1;
        #1;
        check("midrst_duty",   32'(duty),   32'd0);
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_valid",  32'(valid),  32'd0);
        check("midrst_stuck",  32'(stuck),  32'd0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_valid", 32'(vcnt - v0), 32'd0);
        pwm_periods(100, 25, 3);
        check("after_rst_count",  32'(vcnt - v0),  32'd2);
        check("after_rst_period", 32'(last_period), 32'd100);
        check("after_rst_duty",   32'(last_duty),   32'd4);

        // 50 % then 99 % duty.
        do_reset();
        v0 = vcnt;
        pwm_periods(100, 50, 4);
        check("h50_count", 32'(vcnt - v0), 32'd3);
        check("h50_duty",  32'(last_duty), 32'd8);
        v0 = vcnt;
        pwm_periods(100, 99, 3);
        check("h99_count",  32'(vcnt - v0),  32'd3);
        check("h99_duty",   32'(last_duty),  32'd15);
        check("h99_period", 32'(last_period), 32'd100);

        // Period-3 bursts: every other rise lands in DIVIDE and is discarded; then period 20.
        do_reset();
        v0 = vcnt;
        pwm_periods(3, 1, 10);
        pwm_periods(20, 10, 5);
        check("burst_count",  32'(vcnt - v0),  32'd9);
        check("burst_period", 32'(last_period), 32'd20);
        check("burst_duty",   32'(last_duty),   32'd8);

        // Line stuck low, then stuck high, then recovery.
        do_reset();
        v0 = vcnt;
        pwm_periods(100, 50, 3);
        check("pre_tmo_count", 32'(vcnt - v0), 32'd2);
        t_meas = last_valid_cyc;
        v0 = vcnt;
        repeat (2500) @(negedge clk);
        check("low_tmo_count",  32'(vcnt - v0),  32'd1);
        check("low_tmo_stuck",  32'(stuck),      32'd1);
        check("low_tmo_duty",   32'(duty),       32'd0);
        check("low_tmo_period", 32'(period),     32'd0);
        check("low_tmo_time",   32'(last_valid_cyc - t_meas), 32'(TIMEOUT - 5));
        v0 = vcnt;
        pwm_in = 1'b1;
        repeat (6) @(negedge clk);
        check("stuck_clear",    32'(stuck),     32'd0);
        check("clear_no_valid", 32'(vcnt - v0), 32'd0);
        repeat (2500) @(negedge clk);
        check("high_tmo_count", 32'(vcnt - v0), 32'd1);
        check("high_tmo_stuck", 32'(stuck),     32'd1);
        check("high_tmo_duty",  32'(duty),      32'd15);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        v0 = vcnt;
        pwm_periods(100, 50, 3);
        check("recover_stuck",  32'(stuck),       32'd0);
        check("recover_count",  32'(vcnt - v0),   32'd2);
        check("recover_duty",   32'(last_duty),   32'd8);
        check("recover_period", 32'(last_period), 32'd100);

`ifdef PWM_METER_FILTER_EN
        // 2-cycle glitches inside both phases of a 50 % period-200 signal.
        do_reset();
        v0 = vcnt;
        for (int i = 0; i < 4; i++) begin
            pwm_in = 1'b1; repeat (50) @(negedge clk);
            pwm_in = 1'b0; repeat (2)  @(negedge clk);
            pwm_in = 1'b1; repeat (48) @(negedge clk);
            pwm_in = 1'b0; repeat (50) @(negedge clk);
            pwm_in = 1'b1; repeat (2)  @(negedge clk);
            pwm_in = 1'b0; repeat (48) @(negedge clk);
        end
        check("filt_count",  32'(vcnt - v0),  32'd3);
        check("filt_period", 32'(last_period), 32'd200);
        check("filt_duty",   32'(last_duty),   32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
